// File: rtl/shift_pkg.sv
// Shared constants for the parametrised shift/rotate unit: mode codes and
// FSM state encoding.
package shift_pkg;

  // Shift/rotate modes; codes 5..7 are reserved (step counted, data held).
  localparam logic [2:0] MODE_LSL = 3'd0;
  localparam logic [2:0] MODE_LSR = 3'd1;
  localparam logic [2:0] MODE_ASR = 3'd2;
  localparam logic [2:0] MODE_ROL = 3'd3;
  localparam logic [2:0] MODE_ROR = 3'd4;

  // FSM states, kept as plain constants so older tools can share them.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

endpackage

// File: rtl/shift_step.sv
// One 1-bit shift/rotate step. Purely combinational; reserved modes pass the
// current value and carry straight through.
module shift_step
  import shift_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] dout_i,
  input  logic [2:0]            mode_i,
  input  logic                  carry_i,
  output logic [DATA_WIDTH-1:0] next_o,
  output logic                  carry_o
);

  // Select the next register value and the bit that falls out of it.
  always_comb begin
    // NOTE: assigning every output first, before the case, guarantees no
    // path leaves an output unassigned, so no latch can be inferred.
    next_o  = dout_i;
    carry_o = carry_i;
    case (mode_i)
      MODE_LSL: begin
        next_o  = {dout_i[DATA_WIDTH-2:0], 1'b0};
        carry_o = dout_i[DATA_WIDTH-1];
      end
      MODE_LSR: begin
        next_o  = {1'b0, dout_i[DATA_WIDTH-1:1]};
        carry_o = dout_i[0];
      end
      MODE_ASR: begin
        next_o  = {dout_i[DATA_WIDTH-1], dout_i[DATA_WIDTH-1:1]};
        carry_o = dout_i[0];
      end
      MODE_ROL: begin
        next_o  = {dout_i[DATA_WIDTH-2:0], dout_i[DATA_WIDTH-1]};
        carry_o = dout_i[DATA_WIDTH-1];
      end
      MODE_ROR: begin
        next_o  = {dout_i[0], dout_i[DATA_WIDTH-1:1]};
        carry_o = dout_i[0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/param_shift_unit.sv
// Multi-cycle shift/rotate register for the datapath output stage. Loads a
// zero-extended operand, then steps it one bit per cycle for a latched count,
// with a start/busy/done handshake toward the sequencer.
module param_shift_unit
  import shift_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int IN_WIDTH   = 4,
  parameter int AMT_WIDTH  = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [IN_WIDTH-1:0]   din,
  input  logic                  start,
  input  logic [2:0]            mode,
  input  logic [AMT_WIDTH-1:0]  amount,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  busy,
  output logic                  done,
  output logic                  carry,
  output logic                  zero
);

  logic [1:0]            state_q, state_d;
  logic [AMT_WIDTH-1:0]  count_q, count_d;
  logic [2:0]            mode_q,  mode_d;
  logic [DATA_WIDTH-1:0] dout_q,  dout_d;
  logic                  carry_q, carry_d;
  logic [DATA_WIDTH-1:0] step_val;
  logic                  step_carry;

  shift_step #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_step (
    .dout_i (dout_q),
    .mode_i (mode_q),
    .carry_i(carry_q),
    .next_o (step_val),
    .carry_o(step_carry)
  );

  // Next-state logic: handshake FSM, step counter and datapath update.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    mode_d  = mode_q;
    dout_d  = dout_q;
    carry_d = carry_q;
    case (state_q)
      ST_IDLE: begin
        // Load has priority; a simultaneous start is dropped.
        if (load) begin
          dout_d = DATA_WIDTH'(din);
        end else if (start) begin
          mode_d  = mode;
          count_d = amount;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (count_q == '0) begin
          state_d = ST_DONE;
        end else begin
          dout_d  = step_val;
          carry_d = step_carry;
          count_d = count_q - AMT_WIDTH'(1);
          if (count_q == AMT_WIDTH'(1)) state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; reset aborts any operation without a done pulse.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: non-blocking assignments let every register sample the old
    // values at the edge, independent of statement order.
    if (reset) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      mode_q  <= MODE_LSL;
      dout_q  <= '0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      mode_q  <= mode_d;
      dout_q  <= dout_d;
      carry_q <= carry_d;
    end
  end

  assign dout  = dout_q;
  assign carry = carry_q;
  assign busy  = (state_q == ST_SHIFT);
  assign done  = (state_q == ST_DONE);
  assign zero  = (dout_q == '0);

endmodule
